ram_copy_engine: RTL and testbench

RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

---
 rtl/mu0_mem_pkg.sv | 15 +
 rtl/ram_copy_addr_gen.sv | 42 ++++
 rtl/ram_copy_engine.sv | 111 +++++++++++
 tb/tb_ram_copy_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mu0_mem_pkg.sv
// Shared memory-subsystem constants and the copy engine state encoding.
package mu0_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } copy_state_t;

endpackage

// File: rtl/ram_copy_addr_gen.sv
// Source/destination address walker for the copy engine: fixes direction at
// load time and steps both pointers once per copied word, wrapping modulo 2^ADDR_W.
module ram_copy_addr_gen #(
  parameter int ADDR_W = mu0_mem_pkg::ADDR_W,
  parameter int LEN_W  = mu0_mem_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] src_cur,
  output logic [ADDR_W-1:0] dst_cur
);
  import mu0_mem_pkg::*;

  logic              descend;
  logic              descend_nxt;
  logic [ADDR_W-1:0] last_off;

  // A full-memory length truncates to 0, so length-1 lands on the top word.
  assign last_off    = ADDR_W'(length) - ADDR_W'(1);
  assign descend_nxt = (dst_addr > src_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      descend <= 1'b0;
      src_cur <= '0;
      dst_cur <= '0;
    end else if (load) begin
      descend <= descend_nxt;
      src_cur <= descend_nxt ? src_addr + last_off : src_addr;
      dst_cur <= descend_nxt ? dst_addr + last_off : dst_addr;
    end else if (step) begin
      src_cur <= descend ? src_cur - ADDR_W'(1) : src_cur + ADDR_W'(1);
      dst_cur <= descend ? dst_cur - ADDR_W'(1) : dst_cur + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ram_copy_engine.sv
// Word-by-word memmove engine for the single-port registered-read RAM:
// one READ cycle then one WRITE cycle per word.
module ram_copy_engine #(
  parameter int ADDR_W = mu0_mem_pkg::ADDR_W,
  parameter int DATA_W = mu0_mem_pkg::DATA_W,
  parameter int LEN_W  = mu0_mem_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);
  import mu0_mem_pkg::*;

  copy_state_t       state;
  copy_state_t       state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  count_inc;
  logic [ADDR_W-1:0] src_cur;
  logic [ADDR_W-1:0] dst_cur;
  logic              accept;
  logic              step;

  assign accept    = (state == S_IDLE) && start;
  assign step      = (state == S_WRITE);
  assign count_inc = count_q + LEN_W'(1);
  assign count     = count_q;

  ram_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (step),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .src_cur  (src_cur),
    .dst_cur  (dst_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      len_q   <= length;
      count_q <= '0;
    end else if (step) begin
      count_q <= count_inc;
    end
  end

  // Outputs decode from state alone so an asynchronous reset silences the RAM at once.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    ram_address   = '0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (length == LEN_W'(0)) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        ram_address = src_cur;
        ram_read    = 1'b1;
        state_nxt   = S_WRITE;
      end
      S_WRITE: begin
        busy          = 1'b1;
        ram_address   = dst_cur;
        ram_write     = 1'b1;
        ram_writedata = ram_readdata;
        state_nxt     = (count_inc < len_q) ? S_READ : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: a RAM model plus a word-level reference memory
// that replays each copy in the order the engine must perform it.
module tb_ram_copy_engine;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  count;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  logic [DATA_W-1:0] mem     [4096];
  logic [DATA_W-1:0] ref_mem [4096];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_copy_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .count         (count),
    .ram_address   (ram_address),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_writedata (ram_writedata),
    .ram_readdata  (ram_readdata)
  );

  // Single-port RAM with registered read; the preload port is used only while the engine is idle.
  always @(posedge clk) begin
    if (ram_read) ram_readdata <= mem[ram_address];
    if (ram_write) mem[ram_address] <= ram_writedata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_rd"}, ram_read, 0);
    check({tag, "_wr"}, ram_write, 0);
    check({tag, "_addr"}, ram_address, 0);
    check({tag, "_wdata"}, ram_writedata, 0);
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // abort_at >= 0 asserts reset during the READ cycle of that word.
  task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input int len, input int abort_at, input bit noise);
    bit                desc;
    int                idx;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] exp_val;
    desc = (d > s);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = LEN_W'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      idx = desc ? len - 1 - i : i;
      ra  = s + ADDR_W'(idx);
      wa  = d + ADDR_W'(idx);
      check("rd_busy", busy, 1);
      check("rd_strobe", {ram_read, ram_write}, 2'b10);
      check("rd_addr", ram_address, ra);
      check("rd_done", done, 0);
      if (i == abort_at) begin
        start = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("abort_idle");
        check_mem("abort_mem");
        return;
      end
      if (noise) begin
        start    = 1'b1;
        src_addr = ADDR_W'($urandom);
        dst_addr = ADDR_W'($urandom);
        length   = LEN_W'($urandom_range(0, 50));
      end
      @(negedge clk);
      start   = 1'b0;
      exp_val = ref_mem[ra];
      check("wr_busy", busy, 1);
      check("wr_strobe", {ram_read, ram_write}, 2'b01);
      check("wr_addr", ram_address, wa);
      check("wr_data", ram_writedata, exp_val);
      check("wr_count", count, i);
      ref_mem[wa] = exp_val;
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_strobe", {ram_read, ram_write}, 2'b00);
    check("done_addr", ram_address, 0);
    check("done_count", count, len);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_addr", ram_address, 0);
    repeat (2) @(negedge clk);
    check("idle_count_hold", count, len);
    check_mem("mem_image");
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    #2 check_all_zero("reset");

    for (int i = 0; i < 4096; i++) poke(ADDR_W'(i), DATA_W'($urandom));
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    poke(12'h010, 16'hAAAA);
    poke(12'h011, 16'hBBBB);
    poke(12'h012, 16'hCCCC);
    run_copy(12'h010, 12'h100, 3, -1, 1'b0);
    check("asc_w0", mem[12'h100], 16'hAAAA);
    check("asc_w1", mem[12'h101], 16'hBBBB);
    check("asc_w2", mem[12'h102], 16'hCCCC);

    run_copy(12'h050, 12'h060, 0, -1, 1'b0);

    for (int i = 0; i < 4; i++) poke(ADDR_W'(12'h020 + i), DATA_W'(i + 1));
    run_copy(12'h020, 12'h021, 4, -1, 1'b0);
    for (int i = 0; i < 4; i++) check("overlap_word", mem[12'h021 + i], i + 1);

    run_copy(12'hFFE, 12'h200, 3, -1, 1'b0);
    run_copy(12'h300, 12'h340, 8, -1, 1'b1);
    run_copy(12'h400, 12'h480, 10, 4, 1'b0);
    run_copy(12'h400, 12'h480, 10, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_copy(ADDR_W'($urandom), ADDR_W'($urandom), $urandom_range(0, 40), -1, 1'($urandom % 2));
    end

    run_copy(12'h000, 12'h7FF, 4096, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
